// File: rtl/bkm_pkg.sv
// Shared encodings and FSM state type for the BKM digit-selection unit.
package bkm_pkg;

  localparam logic [1:0] D_ZERO = 2'b00;
  localparam logic [1:0] D_POS  = 2'b01;
  localparam logic [1:0] D_NEG  = 2'b11;

  localparam logic MODE_E = 1'b0;
  localparam logic MODE_L = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    EMIT = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic [1:0] neg_digit(input logic [1:0] d);
    logic [1:0] r;
    case (d)
      D_POS:   r = D_NEG;
      D_NEG:   r = D_POS;
      default: r = D_ZERO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csd_window_estimate.sv
// Combinational digit decision for one CSD residual: windowed estimate,
// symmetric threshold, optional negation for L-mode.
module csd_window_estimate
  import bkm_pkg::*;
#(
  parameter int W          = 64,
  parameter int EST_DIGITS = 4,
  parameter int ITW        = 7
) (
  input  logic [2*W-1:0] i_res,
  input  logic [ITW-1:0] i_iter,
  input  logic           i_mode,
  output logic [1:0]     o_digit
);

  localparam int EW2 = 2 * EST_DIGITS;
  localparam int XW  = 2 * W + EW2;
  localparam int SHW = $clog2(2 * W + 1) + 1;
  localparam logic signed [EST_DIGITS:0] THR_P = (EST_DIGITS + 1)'(2 ** (EST_DIGITS - 2));
  localparam logic signed [EST_DIGITS:0] THR_N = -THR_P;

  logic [XW-1:0]         w_ext;
  logic [SHW-1:0]        w_shamt;
  logic [EW2-1:0]        w_win;
  logic [EST_DIGITS-1:0] w_pos;
  logic [EST_DIGITS-1:0] w_neg;
  logic signed [EST_DIGITS:0] w_est;
  logic [1:0]            w_raw;

  // Zero digits appended below the LSD make window positions under 0 read as 0.
  assign w_ext   = {i_res, {EW2{1'b0}}};
  assign w_shamt = SHW'(2 * W) - (SHW'(i_iter) << 1);
  assign w_win   = EW2'(w_ext >> w_shamt);

  always_comb begin
    w_pos = '0;
    w_neg = '0;
    for (int i = 0; i < EST_DIGITS; i++) begin
      w_pos[i] = w_win[2*i+1];
      w_neg[i] = w_win[2*i];
    end
  end

  assign w_est = $signed({1'b0, w_pos}) - $signed({1'b0, w_neg});

  always_comb begin
    if (w_est >= THR_P) begin
      w_raw = D_POS;
    end else if (w_est <= THR_N) begin
      w_raw = D_NEG;
    end else begin
      w_raw = D_ZERO;
    end
  end

  assign o_digit = (i_mode == MODE_L) ? neg_digit(w_raw) : w_raw;

endmodule

// File: rtl/bkm_d_select.sv
// BKM digit-selection sequencer: FSM, iteration counter and registered
// digit outputs around two window estimators (real and imaginary).
module bkm_d_select
  import bkm_pkg::*;
#(
  parameter  int W          = 64,
  parameter  int N_ITER     = W,
  parameter  int EST_DIGITS = 4,
  localparam int ITW        = $clog2(N_ITER + 1)
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           start,
  input  logic           mode,
  input  logic           flush,
  input  logic           res_valid,
  input  logic [2*W-1:0] x_res,
  input  logic [2*W-1:0] y_res,
  output logic [1:0]     d_x,
  output logic [1:0]     d_y,
  output logic           d_valid,
  output logic [ITW-1:0] iter,
  output logic           busy,
  output logic           done
);

  state_t         r_state, w_state_nx;
  logic [ITW-1:0] r_iter, w_iter_nx;
  logic           r_mode, w_mode_nx;
  logic [1:0]     r_dx, w_dx_nx;
  logic [1:0]     r_dy, w_dy_nx;
  logic           r_dvalid, w_dvalid_nx;
  logic           r_busy, w_busy_nx;
  logic           r_done, w_done_nx;
  logic [1:0]     w_dx_est;
  logic [1:0]     w_dy_est;

  csd_window_estimate #(.W(W), .EST_DIGITS(EST_DIGITS), .ITW(ITW)) u_est_x (
    .i_res   (x_res),
    .i_iter  (r_iter),
    .i_mode  (r_mode),
    .o_digit (w_dx_est)
  );

  csd_window_estimate #(.W(W), .EST_DIGITS(EST_DIGITS), .ITW(ITW)) u_est_y (
    .i_res   (y_res),
    .i_iter  (r_iter),
    .i_mode  (r_mode),
    .o_digit (w_dy_est)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_iter_nx   = r_iter;
    w_mode_nx   = r_mode;
    w_dx_nx     = r_dx;
    w_dy_nx     = r_dy;
    w_dvalid_nx = 1'b0;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    if (flush) begin
      w_state_nx = IDLE;
      w_iter_nx  = '0;
      w_busy_nx  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nx = WAIT;
            w_mode_nx  = mode;
            w_iter_nx  = '0;
            w_busy_nx  = 1'b1;
          end else begin
            w_state_nx = IDLE;
          end
        end
        WAIT: begin
          if (res_valid) begin
            w_state_nx  = EMIT;
            w_dx_nx     = w_dx_est;
            w_dy_nx     = w_dy_est;
            w_dvalid_nx = 1'b1;
          end else begin
            w_state_nx = WAIT;
          end
        end
        EMIT: begin
          if (r_iter < ITW'(N_ITER - 1)) begin
            w_state_nx = WAIT;
            w_iter_nx  = r_iter + ITW'(1);
          end else begin
            w_state_nx = DONE;
            w_done_nx  = 1'b1;
          end
        end
        DONE: begin
          w_state_nx = IDLE;
          w_busy_nx  = 1'b0;
        end
        default: begin
          w_state_nx = IDLE;
          w_busy_nx  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= IDLE;
      r_iter   <= '0;
      r_mode   <= MODE_E;
      r_dx     <= D_ZERO;
      r_dy     <= D_ZERO;
      r_dvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_iter   <= w_iter_nx;
      r_mode   <= w_mode_nx;
      r_dx     <= w_dx_nx;
      r_dy     <= w_dy_nx;
      r_dvalid <= w_dvalid_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
    end
  end

  assign d_x     = r_dx;
  assign d_y     = r_dy;
  assign d_valid = r_dvalid;
  assign iter    = r_iter;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_bkm_d_select.sv
// Self-checking bench for bkm_d_select: directed cases plus randomized
// operations checked against an arithmetic reference of the digit rule.
module tb_bkm_d_select;

  localparam int W   = 8;
  localparam int N   = 8;
  localparam int E   = 4;
  localparam int ITW = 4;

  logic           clk = 1'b0;
  logic           arst;
  logic           start;
  logic           mode;
  logic           flush;
  logic           res_valid;
  logic [2*W-1:0] x_res;
  logic [2*W-1:0] y_res;
  logic [1:0]     d_x;
  logic [1:0]     d_y;
  logic           d_valid;
  logic [ITW-1:0] iter;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] xs [N];
  logic [2*W-1:0] ys [N];
  int             gaps [N];
  logic [1:0]     exp_dx = 2'b00;
  logic [1:0]     exp_dy = 2'b00;

  always #5 clk = ~clk;

  bkm_d_select #(.W(W), .N_ITER(N), .EST_DIGITS(E)) dut (
    .clk       (clk),
    .arst      (arst),
    .start     (start),
    .mode      (mode),
    .flush     (flush),
    .res_valid (res_valid),
    .x_res     (x_res),
    .y_res     (y_res),
    .d_x       (d_x),
    .d_y       (d_y),
    .d_valid   (d_valid),
    .iter      (iter),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Digit rule from first principles: signed window sum, threshold, mode sign.
  function automatic logic [1:0] ref_digit(input logic [2*W-1:0] res, input int n, input logic m);
    int r;
    int lo;
    int pos;
    int c;
    r  = 0;
    lo = W - n - E;
    for (int i = 0; i < E; i++) begin
      pos = lo + i;
      if (pos >= 0) r += (int'(res[2*pos+1]) - int'(res[2*pos])) * (2 ** i);
    end
    if (r >= 2 ** (E - 2)) c = 1;
    else if (r <= -(2 ** (E - 2))) c = -1;
    else c = 0;
    if (m) c = -c;
    return (c == 1) ? 2'b01 : ((c == -1) ? 2'b11 : 2'b00);
  endfunction

  task automatic run_op(input logic m, input int flush_at, input int arst_at, input logic poke);
    start = 1'b1; mode = m;
    res_valid = 1'($urandom_range(0, 1)); x_res = 16'($urandom); y_res = 16'($urandom);
    tick();
    start = 1'b0;
    check_eq("busy_rise", 32'(busy), 32'd1);
    check_eq("iter_clear", 32'(iter), 32'd0);
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        res_valid = 1'b0; x_res = 16'($urandom); y_res = 16'($urandom); start = poke;
        tick();
        check_eq($sformatf("gap_dvalid k%0d", k), 32'(d_valid), 32'd0);
        check_eq($sformatf("gap_iter k%0d", k), 32'(iter), 32'(k));
        check_eq($sformatf("hold_dx k%0d", k), 32'(d_x), 32'(exp_dx));
        check_eq($sformatf("hold_dy k%0d", k), 32'(d_y), 32'(exp_dy));
      end
      res_valid = 1'b1; x_res = xs[k]; y_res = ys[k]; start = poke;
      tick();
      start = 1'b0;
      exp_dx = ref_digit(xs[k], k, m);
      exp_dy = ref_digit(ys[k], k, m);
      check_eq($sformatf("strobe k%0d", k), 32'(d_valid), 32'd1);
      check_eq($sformatf("dx k%0d", k), 32'(d_x), 32'(exp_dx));
      check_eq($sformatf("dy k%0d", k), 32'(d_y), 32'(exp_dy));
      check_eq($sformatf("emit_iter k%0d", k), 32'(iter), 32'(k));
      check_eq($sformatf("emit_done k%0d", k), 32'(done), 32'd0);
      if (k == flush_at) begin
        flush = 1'b1; res_valid = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_dvalid", 32'(d_valid), 32'd0);
        check_eq("flush_busy", 32'(busy), 32'd0);
        check_eq("flush_done", 32'(done), 32'd0);
        check_eq("flush_iter", 32'(iter), 32'd0);
        tick();
        check_eq("flush_nodone", 32'(done), 32'd0);
        check_eq("flush_idle", 32'(busy), 32'd0);
        return;
      end
      if (k == arst_at) begin
        #2 arst = 1'b1;
        #1;
        exp_dx = 2'b00; exp_dy = 2'b00;
        check_eq("arst_dvalid", 32'(d_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_iter", 32'(iter), 32'd0);
        check_eq("arst_dx", 32'(d_x), 32'd0);
        arst = 1'b0;
        tick();
        check_eq("arst_nodone", 32'(done), 32'd0);
        check_eq("arst_idle", 32'(busy), 32'd0);
        return;
      end
      res_valid = 1'($urandom_range(0, 1)); x_res = 16'($urandom); y_res = 16'($urandom); start = poke;
      tick();
      start = 1'b0;
      if (k < N - 1) begin
        check_eq($sformatf("wait_dvalid k%0d", k), 32'(d_valid), 32'd0);
        check_eq($sformatf("wait_iter k%0d", k), 32'(iter), 32'(k + 1));
        check_eq($sformatf("wait_busy k%0d", k), 32'(busy), 32'd1);
      end
    end
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd1);
    check_eq("done_dvalid", 32'(d_valid), 32'd0);
    check_eq("done_iter", 32'(iter), 32'(N - 1));
    res_valid = 1'b1;
    tick();
    check_eq("post_done", 32'(done), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_dvalid", 32'(d_valid), 32'd0);
  endtask

  task automatic fill(input logic [2*W-1:0] x, input logic [2*W-1:0] y, input logic rnd, input int gmax);
    for (int k = 0; k < N; k++) begin
      xs[k]   = rnd ? 16'($urandom) : x;
      ys[k]   = rnd ? 16'($urandom) : y;
      gaps[k] = $urandom_range(0, gmax);
    end
  endtask

  initial begin
    arst = 1'b1; start = 1'b0; mode = 1'b0; flush = 1'b0;
    res_valid = 1'b0; x_res = '0; y_res = '0;
    #2;
    check_eq("rst_dx", 32'(d_x), 32'd0);
    check_eq("rst_dy", 32'(d_y), 32'd0);
    check_eq("rst_dvalid", 32'(d_valid), 32'd0);
    check_eq("rst_iter", 32'(iter), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    tick();
    tick();
    arst = 1'b0;
    tick();

    // x digit 7 = +1, y = 0, res_valid held
    fill(16'h8000, 16'h0000, 1'b0, 0);
    run_op(1'b0, -1, -1, 1'b0);
    // x digits 7..4 = 0,-1,-1,0 ; y digits = 0,0,+1,0 ; E then L mode
    fill(16'h1400, 16'h0800, 1'b0, 0);
    run_op(1'b0, -1, -1, 1'b0);
    run_op(1'b1, -1, -1, 1'b0);
    // residual withheld for 5 cycles on two digits
    fill(16'h0000, 16'h0000, 1'b1, 0);
    gaps[0] = 5; gaps[3] = 5;
    run_op(1'b0, -1, -1, 1'b0);
    // flush at iter 3 with start poked throughout the busy period
    fill(16'h0000, 16'h0000, 1'b1, 0);
    run_op(1'b0, 3, -1, 1'b1);
    // asynchronous reset in the middle of an EMIT, then a normal run
    fill(16'h0000, 16'h0000, 1'b1, 1);
    run_op(1'b1, -1, 2, 1'b0);
    fill(16'h0000, 16'h0000, 1'b1, 0);
    run_op(1'b0, -1, -1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      fill(16'h0000, 16'h0000, 1'b1, 3);
      run_op(1'($urandom_range(0, 1)), -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
